// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: filtered three-wire serial receiver with show-ahead FIFO.
// Ports: clk_i/reset_ni clock and async low reset; en_i/scl_i/sda_i async
//   serial link; data_o/valid_o/ready_i head-word handshake; level_o fill
//   count; frame_err_o abort pulse; overrun_o sticky drop flag, clr_i clears.
module serial_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FILT_LEN   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          en_i,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    localparam int SDA = 0;
    localparam int SCL = 1;
    localparam int EN  = 2;

    logic [2:0]          raw;
    logic [FILT_LEN-1:0] samp [3];
    logic [2:0]          s_q;
    logic                d_en;
    logic                d_scl;

    assign raw = {en_i, scl_i, sda_i};

    // The sample shift register doubles as the synchroniser; s_q only
    // moves once the whole window agrees, so short pulses never reach it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int g = 0; g < 3; g++) begin
                samp[g] <= '0;
            end
            s_q   <= '0;
            d_en  <= 1'b0;
            d_scl <= 1'b0;
        end else begin
            for (int g = 0; g < 3; g++) begin
                samp[g] <= {samp[g][FILT_LEN-2:0], raw[g]};
                if (&samp[g]) begin
                    s_q[g] <= 1'b1;
                end else if (~|samp[g]) begin
                    s_q[g] <= 1'b0;
                end
            end
            d_en  <= s_q[EN];
            d_scl <= s_q[SCL];
        end
    end

    logic                  bit_acc;
    logic                  en_fall;
    logic                  push;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] word_nx;

    // Requiring both s and d of enable high masks an scl rise that lands
    // on the enable-fall cycle.
    assign bit_acc = s_q[SCL] & ~d_scl & s_q[EN] & d_en;
    assign en_fall = ~s_q[EN] & d_en;
    assign push    = bit_acc & (cnt == LAST);

    always_comb begin
        word_nx = shreg;
        if (MSB_FIRST) begin
            word_nx = {shreg[DATA_WIDTH-2:0], s_q[SDA]};
        end else begin
            word_nx = {s_q[SDA], shreg[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt         <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (en_fall) begin
                cnt         <= '0;
                shreg       <= '0;
                frame_err_o <= (cnt != '0);
            end else if (bit_acc) begin
                shreg <= word_nx;
                cnt   <= push ? '0 : cnt + CW'(1);
            end
        end
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  wr;
    logic                  drop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = ~empty & ready_i;
    // A pop frees the slot the same edge, so a full FIFO can still accept.
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr      <= '0;
            rptr      <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= word_nx;
                wptr              <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    assign data_o  = mem[rptr[AW-1:0]];
    assign valid_o = ~empty;
    assign level_o = wptr - rptr;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: randomized bench with a behavioural model for two
// serial_rx_fifo instances (8-bit MSB-first and 12-bit LSB-first).
module tb_serial_rx_fifo;

    localparam int F = 3;
    localparam int D = 4;

    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    logic en = 1'b0;
    logic en2 = 1'b0;
    logic scl = 1'b0;
    logic sda = 1'b0;
    logic ready_drv = 1'b0;
    logic clr_drv = 1'b0;
    logic ready_rnd = 1'b0;
    logic clr_rnd = 1'b0;
    logic rnd_on = 1'b0;
    logic ready_i;
    logic clr_i;

    assign ready_i = rnd_on ? ready_rnd : ready_drv;
    assign clr_i   = rnd_on ? clr_rnd : clr_drv;

    logic [7:0]  data0;
    logic        valid0, ferr0, ovr0;
    logic [2:0]  level0;
    logic [11:0] data1;
    logic        valid1, ferr1, ovr1;
    logic [2:0]  level1;

    serial_rx_fifo #(.DATA_WIDTH(8), .FILT_LEN(F), .FIFO_DEPTH(D),
                     .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en), .scl_i(scl),
        .sda_i(sda), .data_o(data0), .valid_o(valid0), .ready_i(ready_i),
        .level_o(level0), .frame_err_o(ferr0), .overrun_o(ovr0),
        .clr_i(clr_i));

    serial_rx_fifo #(.DATA_WIDTH(12), .FILT_LEN(F), .FIFO_DEPTH(D),
                     .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk_i), .reset_ni(reset_ni), .en_i(en2), .scl_i(scl),
        .sda_i(sda), .data_o(data1), .valid_o(valid1), .ready_i(ready_i),
        .level_o(level1), .frame_err_o(ferr1), .overrun_o(ovr1),
        .clr_i(clr_i));

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Filter state as run lengths of identical samples.
    typedef struct {
        int ones;
        int zeros;
        bit s;
        bit d;
    } filt_t;

    function automatic filt_t fstep(filt_t f, bit x);
        filt_t n = f;
        n.d = f.s;
        if (f.ones >= F) n.s = 1'b1;
        else if (f.zeros >= F) n.s = 1'b0;
        n.ones  = x ? f.ones + 1 : 0;
        n.zeros = x ? 0 : f.zeros + 1;
        if (n.ones > 100) n.ones = 100;
        if (n.zeros > 100) n.zeros = 100;
        return n;
    endfunction

    function automatic filt_t freset();
        filt_t f;
        f.ones = 0;
        f.zeros = F;
        f.s = 1'b0;
        f.d = 1'b0;
        return f;
    endfunction

    function automatic int shift_in(int acc, int cnt, bit b, int w, bit msb);
        int a = (cnt == 0) ? 0 : acc;
        if (msb) return ((a << 1) | int'(b)) & ((1 << w) - 1);
        return a | (int'(b) << cnt);
    endfunction

    filt_t fe, fe2, fscl, fsda;
    int cnt0, cnt1, acc0, acc1;
    bit merr0, merr1, movr0, movr1;
    int q0[$];
    int q1[$];

    task automatic model_reset();
        fe = freset(); fe2 = freset(); fscl = freset(); fsda = freset();
        cnt0 = 0; cnt1 = 0; acc0 = 0; acc1 = 0;
        merr0 = 0; merr1 = 0; movr0 = 0; movr1 = 0;
        q0.delete(); q1.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge reset_ni);
            if (!reset_ni) begin
                model_reset();
            end else begin
                bit a0, a1, fl0, fl1, p0, p1, pu0, pu1, full0, full1;
                int w0, w1;
                a0  = fscl.s && !fscl.d && fe.s && fe.d;
                a1  = fscl.s && !fscl.d && fe2.s && fe2.d;
                fl0 = !fe.s && fe.d;
                fl1 = !fe2.s && fe2.d;
                merr0 = fl0 && cnt0 != 0;
                merr1 = fl1 && cnt1 != 0;
                pu0 = 0; pu1 = 0; w0 = 0; w1 = 0;
                if (fl0) cnt0 = 0;
                else if (a0) begin
                    acc0 = shift_in(acc0, cnt0, fsda.s, 8, 1'b1);
                    if (cnt0 == 7) begin pu0 = 1; w0 = acc0; cnt0 = 0; end
                    else cnt0++;
                end
                if (fl1) cnt1 = 0;
                else if (a1) begin
                    acc1 = shift_in(acc1, cnt1, fsda.s, 12, 1'b0);
                    if (cnt1 == 11) begin pu1 = 1; w1 = acc1; cnt1 = 0; end
                    else cnt1++;
                end
                p0 = q0.size() != 0 && ready_i;
                p1 = q1.size() != 0 && ready_i;
                full0 = q0.size() == D;
                full1 = q1.size() == D;
                if (p0) void'(q0.pop_front());
                if (p1) void'(q1.pop_front());
                if (pu0 && (!full0 || p0)) q0.push_back(w0);
                if (pu1 && (!full1 || p1)) q1.push_back(w1);
                if (pu0 && full0 && !p0) movr0 = 1;
                else if (clr_i) movr0 = 0;
                if (pu1 && full1 && !p1) movr1 = 1;
                else if (clr_i) movr1 = 0;
                fe   = fstep(fe, en);
                fe2  = fstep(fe2, en2);
                fscl = fstep(fscl, scl);
                fsda = fstep(fsda, sda);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            chk("valid0", valid0, q0.size() != 0);
            chk("level0", level0, q0.size());
            if (q0.size() != 0) chk("data0", data0, q0[0]);
            chk("ferr0", ferr0, merr0);
            chk("ovr0", ovr0, movr0);
            chk("valid1", valid1, q1.size() != 0);
            chk("level1", level1, q1.size());
            if (q1.size() != 0) chk("data1", data1, q1[0]);
            chk("ferr1", ferr1, merr1);
            chk("ovr1", ovr1, movr1);
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            ready_rnd = 1'($urandom_range(0, 1));
            clr_rnd   = ($urandom_range(0, 15) == 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // mode: 0 plain, 1 pop lands on push edge, 2 latency check, 3 sda spike
    task automatic send_bit(input bit b, input int mode);
        sda = b;
        if (mode == 3 && !b) begin
            tick(1);
            sda = 1'b1;
            tick(2);
            sda = 1'b0;
        end
        tick(F + 1);
        scl = 1'b1;
        if (mode == 1) begin
            tick(F + 1);
            ready_drv = 1'b1;
            tick(1);
            ready_drv = 1'b0;
        end else if (mode == 2) begin
            tick(F + 1);
            chk("lat_before", valid0, 1'b0);
            tick(1);
            chk("lat_at", valid0, 1'b1);
        end else begin
            tick(F + 1);
        end
        scl = 1'b0;
    endtask

    task automatic send_word(input int val, input int w, input bit msb,
                             input int mode);
        for (int i = 0; i < w; i++) begin
            int k = msb ? (w - 1 - i) : i;
            bit b = 1'((val >> k) & 1);
            int m = mode;
            if ((mode == 1 || mode == 2) && i != w - 1) m = 0;
            send_bit(b, m);
        end
        tick(F + 3);
    endtask

    task automatic pop_one();
        ready_drv = 1'b1;
        tick(1);
        ready_drv = 1'b0;
    endtask

    task automatic count_ferr(input string name, input int exp);
        int n = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (ferr0) n++;
        end
        chk(name, n, exp);
    endtask

    initial begin
        tick(3);
        chk("rst_valid", valid0, 0);
        chk("rst_level", level0, 0);
        chk("rst_data", data0, 0);
        chk("rst_ovr", ovr0, 0);
        reset_ni = 1'b1;
        tick(2);

        en = 1'b1;
        tick(F + 1);
        send_word(8'hA5, 8, 1'b1, 2);
        chk("a5_valid", valid0, 1);
        chk("a5_data", data0, 8'hA5);
        chk("a5_level", level0, 1);
        pop_one();
        chk("a5_popped", valid0, 0);

        en = 1'b0;
        en2 = 1'b1;
        tick(F + 1);
        send_word(12'h801, 12, 1'b0, 0);
        chk("lsb_valid", valid1, 1);
        chk("lsb_data", data1, 12'h801);
        chk("lsb_main_idle", level0, 0);
        pop_one();
        en2 = 1'b0;
        tick(F + 3);

        en = 1'b1;
        tick(F + 1);
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
        send_bit(1, 0); send_bit(0, 0);
        tick(2);
        en = 1'b0;
        count_ferr("abort_pulse", 1);
        chk("abort_nopush", level0, 0);
        en = 1'b1;
        tick(F + 1);
        send_word(8'h3C, 8, 1'b1, 0);
        chk("after_abort", data0, 8'h3C);
        chk("after_abort_lvl", level0, 1);
        pop_one();

        for (int i = 1; i <= 5; i++) send_word(i, 8, 1'b1, 0);
        chk("ovr_level", level0, 4);
        chk("ovr_flag", ovr0, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_pop", data0, i);
            pop_one();
        end
        chk("ovr_empty", valid0, 0);
        clr_drv = 1'b1;
        tick(1);
        clr_drv = 1'b0;
        chk("ovr_clr", ovr0, 0);

        for (int i = 1; i <= 4; i++) send_word(i, 8, 1'b1, 0);
        send_word(8'h77, 8, 1'b1, 1);
        chk("cpp_level", level0, 4);
        chk("cpp_ovr", ovr0, 0);
        for (int i = 2; i <= 4; i++) begin
            chk("cpp_pop", data0, i);
            pop_one();
        end
        chk("cpp_last", data0, 8'h77);
        pop_one();

        repeat (3) begin
            scl = 1'b1;
            tick(2);
            scl = 1'b0;
            tick(F + 1);
        end
        en = 1'b0;
        count_ferr("glitch_nocount", 0);
        en = 1'b1;
        tick(F + 1);
        send_word(8'h81, 8, 1'b1, 3);
        chk("glitch_data", data0, 8'h81);
        chk("glitch_level", level0, 1);
        pop_one();

        for (int i = 0; i < 5; i++) send_word(8'h11 + i, 8, 1'b1, 0);
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        reset_ni = 1'b0;
        #1;
        chk("arst_valid", valid0, 0);
        chk("arst_level", level0, 0);
        chk("arst_data", data0, 0);
        chk("arst_ovr", ovr0, 0);
        chk("arst_ferr", ferr0, 0);
        tick(2);
        reset_ni = 1'b1;
        tick(F + 2);
        send_word(8'h5A, 8, 1'b1, 0);
        chk("arst_next", data0, 8'h5A);
        chk("arst_next_lvl", level0, 1);
        pop_one();

        rnd_on = 1'b1;
        repeat (8) begin
            int n = $urandom_range(5, 40);
            en = 1'b1;
            en2 = 1'b1;
            tick(F + 1);
            for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 0);
            tick($urandom_range(1, 6));
            en = 1'($urandom_range(0, 1));
            en2 = 1'b0;
            tick(F + 3);
            en = 1'b0;
            tick(F + 3);
        end
        rnd_on = 1'b0;
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
